sqrt_param: RTL

SQRT_PARAM -- requirements
Module: sqrt_param

---
 rtl/sqrt_pkg.sv | 13 +
 rtl/sqrt_param.sv | 107 ++++++++++
 2 files changed

// File: rtl/sqrt_pkg.sv
// Shared definitions for the iterative square-root unit: FSM encoding and
// the default radicand width.
package sqrt_pkg;

    localparam int unsigned SQRT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sqrt_param.sv
// Iterative digit-by-digit integer square root: one result bit per cycle,
// MSB first, with optional round-to-nearest on the registered result.
module sqrt_param
    import sqrt_pkg::*;
#(
    parameter int unsigned W     = SQRT_W_DEFAULT,
    parameter int unsigned ROUND = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [W-1:0]     x_bi,
    output logic             busy_o,
    output logic             done_o,
    output logic [W/2-1:0]   y_bo,
    output logic [W/2:0]     rem_bo
);

    localparam int unsigned H  = W / 2;
    localparam int unsigned CW = $clog2(H);

    state_t          r_state;
    state_t          w_state_next;
    logic [W-1:0]    r_x;
    logic [H-1:0]    r_root;
    logic [H-1:0]    r_rem;
    logic [CW-1:0]   r_cnt;
    logic [H-1:0]    r_y;
    logic [H:0]      r_rem_out;

    logic            w_accept;
    logic            w_last;
    logic [H+1:0]    w_rem_sh;
    logic [H+1:0]    w_trial;
    logic [H+1:0]    w_sub;
    logic            w_borrow;
    logic [H:0]      w_rem_next;
    logic [H-1:0]    w_root_next;
    logic            w_round_up;
    logic [H-1:0]    w_y_final;

    assign w_accept = start_i && (r_state != ST_CALC);
    assign w_last   = (r_cnt == CW'(H - 1));

    // A negative difference always lands above 2^(H+1) and a valid remainder
    // never reaches it, so the top bit of the subtractor doubles as borrow.
    assign w_rem_sh    = {r_rem, r_x[W-1 -: 2]};
    assign w_trial     = {r_root, 2'b01};
    assign w_sub       = w_rem_sh - w_trial;
    assign w_borrow    = w_sub[H+1];
    assign w_rem_next  = w_borrow ? w_rem_sh[H:0] : w_sub[H:0];
    assign w_root_next = {r_root[H-2:0], ~w_borrow};

    assign w_round_up = (ROUND != 0) && ({1'b0, w_root_next} < w_rem_next);
    assign w_y_final  = (w_round_up && !(&w_root_next)) ? w_root_next + 1'b1
                                                         : w_root_next;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start_i) w_state_next = ST_CALC;
            ST_CALC: if (w_last)  w_state_next = ST_DONE;
            ST_DONE: w_state_next = start_i ? ST_CALC : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: every register here uses <= so all of them see pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_x       <= '0;
            r_root    <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_y       <= '0;
            r_rem_out <= '0;
        end else if (w_accept) begin
            r_x    <= x_bi;
            r_root <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
        end else if (r_state == ST_CALC) begin
            r_x    <= r_x << 2;
            r_root <= w_root_next;
            r_rem  <= w_rem_next[H-1:0];
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) begin
                r_y       <= w_y_final;
                r_rem_out <= w_rem_next;
            end
        end
    end

    assign busy_o = (r_state == ST_CALC);
    assign done_o = (r_state == ST_DONE);
    assign y_bo   = r_y;
    assign rem_bo = r_rem_out;

endmodule
